pwm_decoder: RTL and testbench
==============================

PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the high-time and period counters and outputs.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pwm_in  input  1  PWM waveform, asynchronous to clk.
REQ-005 SHALL have port high_time  output  CNT_W  clk cycles the input was high in the last complete period.
REQ-006 SHALL have port period  output  CNT_W  clk cycles between the last two rising edges.
REQ-007 SHALL have port valid  output  1  one-cycle strobe when high_time/period update.
REQ-008 SHALL have port stuck  output  1  no edge seen for 2^CNT_W-1 cycles.
REQ-009 SHALL have port stuck_level  output  1  synchronized input level while stuck is high; 0 otherwise.

Function
REQ-010 SHALL synchronize pwm_in through two flops, then detect edges by comparing it with a third registered copy (the sample input s).
REQ-011 SHALL implement states IDLE, HIGH, LOW and STUCK.
REQ-012 IDLE: on a rising edge of s go to HIGH, hi_cnt=1, per_cnt=1; no valid pulse for this first edge.
REQ-013 HIGH: increment hi_cnt and per_cnt each cycle; on a falling edge latch hi_cnt into a hold register and go to LOW.
REQ-014 LOW: increment per_cnt; on a rising edge drive high_time=hold, period=per_cnt, pulse valid on the next cycle, restart hi_cnt=1, per_cnt=1, go to HIGH.
REQ-015 Counts SHALL equal exact cycle counts of s; a steady waveform of H cycles high and P cycles per period SHALL yield high_time=H, period=P.
REQ-016 The latency from a pwm_in rising edge to valid SHALL be 4 clk cycles without the filter (REQ-026) and 6 with it.
REQ-017 If per_cnt reaches 2^CNT_W-1 in any state other than STUCK, the block SHALL enter STUCK, assert stuck, drive stuck_level=s, and leave high_time/period unchanged.
REQ-018 In STUCK, stuck_level SHALL track s and the counters SHALL hold.
REQ-019 In STUCK, a rising edge SHALL behave as in IDLE (clear stuck, go to HIGH, no valid pulse); a falling edge SHALL only update stuck_level.
REQ-020 Counters SHALL never wrap; saturation always enters STUCK.
REQ-021 valid SHALL be exactly one cycle wide; high_time and period SHALL be stable between valid pulses.
REQ-022 Edges on consecutive cycles (1-cycle high pulse) SHALL yield high_time=1.

Reset
REQ-023 Asserting reset at any time SHALL immediately force state=IDLE, all counters and the hold register to 0, high_time=0, period=0, valid=0, stuck=0, stuck_level=0.
REQ-024 Synchronizer flops SHALL reset to 0, so a high input at reset release appears as a rising edge.
REQ-025 A measurement interrupted by reset SHALL be discarded; no valid pulse after release until one full period is seen.

Configuration
REQ-026 With PWM_DECODER_GLITCH_FILTER_EN defined, s SHALL change only after three consecutive equal synchronized samples (pulses under 3 cycles are ignored, 2 extra cycles of latency); without it, s SHALL be the synchronized input directly.

Structure
REQ-027 Package pwm_pkg SHALL hold the state enumeration and the CNT_W default constant.
REQ-028 Synchronizer, optional glitch filter and edge detector SHALL be the sub-module pwm_edge_sync (outputs s, rise, fall).

Verification
REQ-029 Input 5 high / 11 low, repeated -> from the second rising edge on, valid every 16 cycles with high_time=5, period=16.
REQ-030 Input held 0 after reset -> stuck=1 and stuck_level=0 after 65535 cycles; valid never asserted.
REQ-031 Input held 1 -> stuck=1, stuck_level=1; then a 3-low/13-high pattern -> stuck clears on the rising edge and the first valid reports high_time=13, period=16.
REQ-032 1-cycle high pulse every 8 cycles, filter off -> high_time=1, period=8; filter on -> no valid, stuck after timeout.
REQ-033 reset asserted mid-HIGH with input toggling -> all outputs 0 immediately; the first valid comes only after a complete post-reset period.
REQ-034 Input driven by the team's PWM generator at level 9 (16-cycle period) -> high_time=9, period=16.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM decoder: default counter width and FSM state codes.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_STUCK = 2'd3;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for the PWM decoder: two-flop synchronizer, optional
// glitch filter (PWM_DECODER_GLITCH_FILTER_EN), and rise/fall detection on s.
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic sync1, sync2, s_d;

  // Two-flop synchronizer; resets low so a high input at release shows as a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic hist, s_q;

  // s follows only after three consecutive equal samples (sync1 is the next sync2)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      hist <= sync2;
      if (sync1 == sync2 && sync2 == hist) s_q <= sync1;
    end
  end

  assign s = s_q;
`else
  assign s = sync2;
`endif

  // Delayed copy of s for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_d <= 1'b0;
    else       s_d <= s;
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and period of pwm_in in clk cycles and flags
// a stuck input after 2^CNT_W-1 cycles without a rising edge.
// Optional glitch filter: define PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s, rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] hi_cnt, per_cnt, hold;
  logic [CNT_W-1:0] cap_ht, cap_per;
  logic             cap_vld;

  pwm_edge_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  // Measurement FSM; saturating per_cnt forces STUCK instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hi_cnt      <= '0;
      per_cnt     <= '0;
      hold        <= '0;
      cap_ht      <= '0;
      cap_per     <= '0;
      cap_vld     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      cap_vld <= 1'b0;
      case (state)
        ST_HIGH: begin
          if (per_cnt == CNT_MAX) begin
            state       <= ST_STUCK;
            stuck       <= 1'b1;
            stuck_level <= s;
          end else begin
            per_cnt <= per_cnt + ONE;
            if (fall) begin
              hold  <= hi_cnt;
              state <= ST_LOW;
            end else begin
              hi_cnt <= hi_cnt + ONE;
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            cap_ht  <= hold;
            cap_per <= per_cnt;
            cap_vld <= 1'b1;
            hi_cnt  <= ONE;
            per_cnt <= ONE;
            state   <= ST_HIGH;
          end else if (per_cnt == CNT_MAX) begin
            state       <= ST_STUCK;
            stuck       <= 1'b1;
            stuck_level <= s;
          end else begin
            per_cnt <= per_cnt + ONE;
          end
        end
        default: begin
          // IDLE and STUCK: a rising edge starts a fresh measurement, no report
          if (rise) begin
            state       <= ST_HIGH;
            hi_cnt      <= ONE;
            per_cnt     <= ONE;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
          end else if (state == ST_STUCK) begin
            stuck_level <= s;
          end else if (per_cnt == CNT_MAX) begin
            state       <= ST_STUCK;
            stuck       <= 1'b1;
            stuck_level <= s;
          end else begin
            per_cnt <= per_cnt + ONE;
          end
        end
      endcase
    end
  end

  // Output stage: results and the valid strobe update together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= cap_vld;
      if (cap_vld) begin
        high_time <= cap_ht;
        period    <= cap_per;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder (CNT_W=8 so stuck timeouts are short).
// Reference model works on pwm_in edge times: each rising edge that closes a
// full observed period predicts one valid LAT cycles later.
module tb_pwm_decoder;

  localparam int W = 8;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_time, period;
  logic         valid, stuck, stuck_level;

  pwm_decoder #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .high_time(high_time), .period(period), .valid(valid),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  typedef struct { int ht; int per; int when; } exp_t;
  typedef struct { int h; int l; int n; int eht; int eper; } vec_t;

  int   errors = 0, checks = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   have_rise = 0, have_fall = 0;
  int   rise_c = 0, fall_c = 0;
  int   hold_ht = 0, hold_per = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    have_rise = 0;
    have_fall = 0;
  endtask

  // One clock of stimulus; records edges of pwm_in for the model
  task automatic step(input logic v);
    exp_t e;
    @(posedge clk); #1;
    if (!reset) begin
      if (v && !pwm_in) begin
        if (have_rise && have_fall) begin
          e.ht = fall_c - rise_c; e.per = cyc - rise_c; e.when = cyc + LAT;
          q.push_back(e);
        end
        rise_c = cyc; have_rise = 1; have_fall = 0;
      end
      if (!v && pwm_in && have_rise) begin
        fall_c = cyc; have_fall = 1;
      end
    end
    pwm_in = v;
  endtask

  task automatic do_reset(input logic lvl);
    @(posedge clk); #1;
    pwm_in = lvl;
    reset = 1'b1;
    q.delete();
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_pat(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) step(1'b1);
      for (int i = 0; i < l; i++) step(1'b0);
    end
  endtask

  task automatic drained(input string name);
    chk(name, q.size(), 0);
  endtask

  task automatic wait_stuck(input logic lvl, input int maxc, output int n);
    n = 0;
    while (!stuck && n < maxc) begin
      step(lvl);
      n++;
    end
    if (!stuck) begin
      errors++;
      $display("FAIL stuck_timeout: stuck not seen within %0d cycles", maxc);
    end
  endtask

  // Monitor: every valid must match the model in values and timing; outputs
  // must hold steady between strobes
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_ht  <= 0;
      hold_per <= 0;
    end else if (valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: ht=%0d per=%0d at cycle %0d, none expected", high_time, period, cyc);
      end else begin
        e = q.pop_front();
        chk("valid_time", cyc, e.when);
        chk("valid_ht", int'(high_time), e.ht);
        chk("valid_per", int'(period), e.per);
      end
      hold_ht  <= int'(high_time);
      hold_per <= int'(period);
    end else begin
      chk("stable_ht", int'(high_time), hold_ht);
      chk("stable_per", int'(period), hold_per);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  int   nvec;
  int   n;

  initial begin
    tbl[0] = '{5, 11, 4, 5, 16};
    tbl[1] = '{9, 7, 4, 9, 16};
    tbl[2] = '{3, 13, 3, 3, 16};
    tbl[3] = '{8, 8, 3, 8, 16};
    tbl[4] = '{12, 4, 3, 12, 16};
    tbl[5] = '{1, 7, 4, 1, 8};
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    nvec = 5;
`else
    nvec = 6;
`endif

    // Reset state
    pwm_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ht", int'(high_time), 0);
    chk("rst_per", int'(period), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_level", int'(stuck_level), 0);

    // Table-driven steady waveforms
    for (int v = 0; v < nvec; v++) begin
      do_reset(1'b0);
      repeat (4) step(1'b0);
      run_pat(tbl[v].h, tbl[v].l, tbl[v].n);
      repeat (LAT + 4) step(1'b0);
      chk("tbl_ht", int'(high_time), tbl[v].eht);
      chk("tbl_per", int'(period), tbl[v].eper);
      chk("tbl_stuck", int'(stuck), 0);
      drained("tbl_drain");
    end

    // Held low: timeout into STUCK with level 0, no valid
    do_reset(1'b0);
    wait_stuck(1'b0, 400, n);
    checks++;
    if (n < 250 || n > 270) begin
      errors++;
      $display("FAIL stuck0_delay: %0d cycles, expected 250..270", n);
    end
    step(1'b0); step(1'b0);
    chk("stuck0_level", int'(stuck_level), 0);
    chk("stuck0_ht", int'(high_time), 0);
    drained("stuck0_drain");

    // Held high: STUCK level 1, falling edge only moves stuck_level, then recovery
    do_reset(1'b1);
    wait_stuck(1'b1, 400, n);
    step(1'b1); step(1'b1);
    chk("stuck1_level", int'(stuck_level), 1);
    repeat (8) step(1'b0);
    chk("stuck1_fall_stuck", int'(stuck), 1);
    chk("stuck1_fall_level", int'(stuck_level), 0);
    run_pat(13, 3, 4);
    chk("stuck1_cleared", int'(stuck), 0);
    repeat (LAT + 4) step(1'b0);
    chk("stuck1_ht", int'(high_time), 13);
    chk("stuck1_per", int'(period), 16);
    drained("stuck1_drain");

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    // 1-cycle pulses are filtered out: no valid, timeout into STUCK
    do_reset(1'b0);
    model_clear();
    n = 0;
    while (!stuck && n < 50) begin
      step(1'b1);
      repeat (7) step(1'b0);
      model_clear();
      q.delete();
      n++;
    end
    chk("filt_stuck", int'(stuck), 1);
    chk("filt_level", int'(stuck_level), 0);
    chk("filt_ht", int'(high_time), 0);
`endif

    // Reset mid-HIGH: outputs clear at once, first valid only after a full period
    do_reset(1'b0);
    repeat (4) step(1'b0);
    run_pat(5, 11, 3);
    step(1'b1); step(1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ht", int'(high_time), 0);
    chk("midrst_per", int'(period), 0);
    chk("midrst_valid", int'(valid), 0);
    q.delete();
    model_clear();
    for (int i = 0; i < 6; i++) step(i[0]);
    step(1'b0);
    #1 reset = 1'b0;
    repeat (3) step(1'b0);
    run_pat(5, 11, 3);
    repeat (LAT + 4) step(1'b0);
    chk("midrst_final_ht", int'(high_time), 5);
    drained("midrst_drain");

    // Randomized waveform against the model
    do_reset(1'b0);
    repeat (4) step(1'b0);
    for (int p = 0; p < 30; p++)
      run_pat(int'($urandom_range(3, 20)), int'($urandom_range(3, 20)), 1);
    repeat (LAT + 4) step(1'b0);
    chk("rand_stuck", int'(stuck), 0);
    drained("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
